// File: rtl/fp32_pkg.sv
// Shared float32 constants and converter FSM encodings for the ADC-to-float feeder.
package fp32_pkg;

  localparam int          FP32_BIAS   = 127;
  localparam int          FP32_MANT_W = 23;
  localparam int          FP32_EXP_W  = 8;
  localparam logic [31:0] FP32_ZERO   = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ABS  = 2'd1,
    S_NORM = 2'd2,
    S_OUT  = 2'd3
  } conv_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; a push while full is rejected even if a pop coincides.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_to_float_feeder.sv
// Buffers signed 24-bit ADC samples and converts each one exactly to float32 scaled by 2^-SCALE_EXP.
module adc_to_float_feeder
  import fp32_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SCALE_EXP  = 0
) (
  input  logic        i_CLK,
  input  logic        i_RSTN,
  input  logic [23:0] i_ADC_DATA,
  input  logic        i_ADC_DATA_VALID,
  output logic        o_ADC_DATA_READY,
  output logic [31:0] o_X_DATA,
  output logic        o_X_DATA_VALID,
  input  logic        i_X_DATA_READY,
  output logic [7:0]  o_DROP_CNT
);

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [23:0]        fifo_dout;

  conv_state_t        state;
  logic signed [23:0] work;
  logic               sign;
  logic [23:0]        mag;
  logic               zflag;
  logic [4:0]         shift;

  // |-2^23| = 0x800000 still fits once read back as unsigned.
  function automatic logic [23:0] abs_mag(input logic signed [23:0] x);
    return x[23] ? $unsigned(-x) : $unsigned(x);
  endfunction

  // The 24-bit magnitude fills the significand exactly, so no rounding is needed.
  function automatic logic [31:0] pack_fp32(input logic s, input logic [4:0] lz,
                                            input logic [23:0] m);
    logic [FP32_EXP_W-1:0] e;
    e = FP32_EXP_W'(FP32_BIAS + FP32_MANT_W - int'(lz) - SCALE_EXP);
    return {s, e, m[FP32_MANT_W-1:0]};
  endfunction

  assign o_ADC_DATA_READY = !fifo_full;
  assign fifo_push        = i_ADC_DATA_VALID && !fifo_full;
  assign fifo_pop         = (state == S_IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_CLK),
    .rst_n (i_RSTN),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (i_ADC_DATA),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      o_DROP_CNT <= '0;
    end else if (i_ADC_DATA_VALID && fifo_full && (o_DROP_CNT != 8'hFF)) begin
      o_DROP_CNT <= o_DROP_CNT + 8'd1;
    end
  end

  // Normaliser datapath; only ever consumed in states reached after a pop.
  always_ff @(posedge i_CLK) begin
    case (state)
      S_IDLE: if (!fifo_empty) work <= signed'(fifo_dout);
      S_ABS: begin
        sign  <= work[23];
        mag   <= abs_mag(work);
        zflag <= (work == '0);
      end
      S_NORM: if (!zflag && !mag[23]) mag <= mag << 1;
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state          <= S_IDLE;
      shift          <= '0;
      o_X_DATA       <= FP32_ZERO;
      o_X_DATA_VALID <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!fifo_empty) state <= S_ABS;
        S_ABS: begin
          shift <= '0;
          state <= S_NORM;
        end
        S_NORM: begin
          if (zflag) begin
            o_X_DATA       <= FP32_ZERO;
            o_X_DATA_VALID <= 1'b1;
            state          <= S_OUT;
          end else if (!mag[23]) begin
            shift <= shift + 5'd1;
          end else begin
            o_X_DATA       <= pack_fp32(sign, shift, mag);
            o_X_DATA_VALID <= 1'b1;
            state          <= S_OUT;
          end
        end
        S_OUT: begin
          if (i_X_DATA_READY) begin
            o_X_DATA_VALID <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_to_float_feeder.sv
// Directed bench for adc_to_float_feeder: conversions, latency, backpressure, drops and async reset.
module tb_adc_to_float_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] adc_data;
  logic        adc_valid;
  logic        adc_ready;
  logic [31:0] x_data;
  logic        x_valid;
  logic        x_ready;
  logic [7:0]  drop_cnt;

  logic [23:0] adc_data2;
  logic        adc_valid2;
  logic        adc_ready2;
  logic [31:0] x_data2;
  logic        x_valid2;
  logic [7:0]  drop_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_to_float_feeder #(.FIFO_DEPTH(4), .SCALE_EXP(0)) dut (
    .i_CLK            (clk),
    .i_RSTN           (rst_n),
    .i_ADC_DATA       (adc_data),
    .i_ADC_DATA_VALID (adc_valid),
    .o_ADC_DATA_READY (adc_ready),
    .o_X_DATA         (x_data),
    .o_X_DATA_VALID   (x_valid),
    .i_X_DATA_READY   (x_ready),
    .o_DROP_CNT       (drop_cnt)
  );

  adc_to_float_feeder #(.FIFO_DEPTH(4), .SCALE_EXP(23)) dut_scaled (
    .i_CLK            (clk),
    .i_RSTN           (rst_n),
    .i_ADC_DATA       (adc_data2),
    .i_ADC_DATA_VALID (adc_valid2),
    .o_ADC_DATA_READY (adc_ready2),
    .o_X_DATA         (x_data2),
    .o_X_DATA_VALID   (x_valid2),
    .i_X_DATA_READY   (1'b1),
    .o_DROP_CNT       (drop_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one sample to an idle DUT and verify the k+3+s latency and the handshake.
  task automatic convert(input logic [23:0] x, input logic [31:0] exp, input int s,
                         input string tag);
    adc_data  = x;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    for (int i = 0; i < 2 + s; i++) tick();
    chk({tag, "_early"}, {31'b0, x_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'b0, x_valid}, 32'd1);
    chk({tag, "_data"}, x_data, exp);
    tick();
    chk({tag, "_done"}, {31'b0, x_valid}, 32'd0);
    chk({tag, "_hold"}, x_data, exp);
  endtask

  logic [23:0] t4_in  [6];
  logic [31:0] t4_out [5];

  initial begin
    int n;
    logic seen;

    rst_n      = 1'b0;
    adc_data   = '0;
    adc_valid  = 1'b0;
    x_ready    = 1'b1;
    adc_data2  = '0;
    adc_valid2 = 1'b0;
    #1;
    chk("rst_data", x_data, 32'h0);
    chk("rst_valid", {31'b0, x_valid}, 32'd0);
    chk("rst_drop", {24'b0, drop_cnt}, 32'd0);
    chk("rst_ready", {31'b0, adc_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    convert(24'h000001, 32'h3F800000, 23, "t1_one");
    convert(24'h800000, 32'hCB000000, 0, "t2_minfs");
    convert(24'h000002, 32'h40000000, 22, "t2_two");
    convert(24'hFFFFFE, 32'hC0000000, 22, "t2_mtwo");
    convert(24'h000000, 32'h00000000, 0, "t3_zero");
    convert(24'h7FFFFF, 32'h4AFFFFFE, 1, "t3_maxfs");

    // Backpressure: 5 samples fit (4 in FIFO + 1 converting), the 6th is dropped.
    t4_in  = '{24'h000001, 24'h000002, 24'h000003, 24'h000004, 24'hFFFFFF, 24'h000008};
    t4_out = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'hBF800000};
    x_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      adc_data  = t4_in[i];
      adc_valid = 1'b1;
      chk($sformatf("t4_ready%0d", i), {31'b0, adc_ready}, (i == 5) ? 32'd0 : 32'd1);
      tick();
    end
    adc_valid = 1'b0;
    chk("t4_drop", {24'b0, drop_cnt}, 32'd1);
    for (int i = 0; i < 30; i++) tick();
    chk("t4_stall_valid", {31'b0, x_valid}, 32'd1);
    chk("t4_stall_data", x_data, t4_out[0]);
    for (int i = 0; i < 3; i++) tick();
    chk("t4_stall_valid2", {31'b0, x_valid}, 32'd1);
    chk("t4_stall_data2", x_data, t4_out[0]);
    chk("t4_full", {31'b0, adc_ready}, 32'd0);
    x_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (!x_valid && n < 40) begin
        tick();
        n++;
      end
      chk($sformatf("t4_out%0d_valid", j), {31'b0, x_valid}, 32'd1);
      chk($sformatf("t4_out%0d_data", j), x_data, t4_out[j]);
      tick();
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (x_valid) seen = 1'b1;
    end
    chk("t4_no_extra", {31'b0, seen}, 32'd0);
    chk("t4_ready_after", {31'b0, adc_ready}, 32'd1);

    // Async reset while the converter is normalising x=1.
    adc_data  = 24'h000001;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_data", x_data, 32'h0);
    chk("t5_rst_valid", {31'b0, x_valid}, 32'd0);
    chk("t5_rst_drop", {24'b0, drop_cnt}, 32'd0);
    chk("t5_rst_ready", {31'b0, adc_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (x_valid) seen = 1'b1;
    end
    chk("t5_no_emit", {31'b0, seen}, 32'd0);
    convert(24'h000002, 32'h40000000, 22, "t5_after");

    // Scaled instance: 0x400000 * 2^-23 = 0.5.
    adc_data2  = 24'h400000;
    adc_valid2 = 1'b1;
    tick();
    adc_valid2 = 1'b0;
    n = 0;
    while (!x_valid2 && n < 20) begin
      tick();
      n++;
    end
    chk("t6_lat", n, 32'd4);
    chk("t6_valid", {31'b0, x_valid2}, 32'd1);
    chk("t6_data", x_data2, 32'h3F000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
